int_sched: RTL and testbench

//  Interrupt scheduler and flush controller for the 5-stage pipeline.

---
 rtl/int_sched.sv | 127 ++++++++++++
 tb/tb_int_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/int_sched.sv
// rtl/int_sched.sv - single-level interrupt scheduler and pipeline flush controller
module int_sched #(
    parameter int               N_IRQ      = 3,
    parameter logic [31:0]      VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0]      VEC_STRIDE = 32'h0000_0010,
    parameter logic [N_IRQ-1:0] MASK_RST   = '0,
    localparam int              IW         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             ie_i,
    input  logic             halt_i,
    input  logic             stall_i,
    input  logic             mask_we_i,
    input  logic [N_IRQ-1:0] mask_din_i,
    input  logic [31:0]      npc_i,
    input  logic             eret_i,
    output logic             interrupt_o,
    output logic             pc_load_o,
    output logic [31:0]      pc_target_o,
    output logic [31:0]      epc_o,
    output logic             in_svc_o,
    output logic [IW-1:0]    cur_irq_o,
    output logic [N_IRQ-1:0] pending_o,
    output logic [N_IRQ-1:0] mask_o
);

    typedef enum logic [1:0] {IDLE, TAKE, SERVE, RET} state_t;

    state_t             state_q;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [N_IRQ-1:0]   irq_prev_q;
    logic [N_IRQ-1:0]   mask_q;
    logic [31:0]        epc_q;
    logic [31:0]        pc_target_q;
    logic [IW-1:0]      cur_q;
    logic               interrupt_q, pc_load_q, in_svc_q;

    logic [N_IRQ-1:0]   eligible;
    logic [IW-1:0]      winner;
    logic               found;
    logic               take;

    always_comb begin
        eligible = pending_q & ~mask_q;
        winner   = '0;
        found    = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eligible[i] && !found) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
        take = (state_q == IDLE) && ie_i && !halt_i && !stall_i && (|eligible);
        // Clear the taken bit first so a coincident new edge re-pends it.
        pending_d = pending_q;
        if (take) begin
            pending_d[winner] = 1'b0;
        end
        pending_d = pending_d | (irq_i & ~irq_prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            irq_prev_q  <= '0;
            mask_q      <= MASK_RST;
            epc_q       <= '0;
            cur_q       <= '0;
            pc_target_q <= '0;
            interrupt_q <= 1'b0;
            pc_load_q   <= 1'b0;
            in_svc_q    <= 1'b0;
        end else begin
            irq_prev_q  <= irq_i;
            pending_q   <= pending_d;
            if (mask_we_i) begin
                mask_q <= mask_din_i;
            end
            interrupt_q <= 1'b0;
            pc_load_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q     <= TAKE;
                        cur_q       <= winner;
                        epc_q       <= npc_i;
                        pc_target_q <= VEC_BASE + 32'(winner) * VEC_STRIDE;
                        interrupt_q <= 1'b1;
                        pc_load_q   <= 1'b1;
                        in_svc_q    <= 1'b1;
                    end
                end
                TAKE: begin
                    state_q <= SERVE;
                end
                SERVE: begin
                    if (eret_i) begin
                        state_q     <= RET;
                        pc_target_q <= epc_q;
                        pc_load_q   <= 1'b1;
                        in_svc_q    <= 1'b0;
                    end
                end
                RET: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    in_svc_q <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_o = interrupt_q;
    assign pc_load_o   = pc_load_q;
    assign pc_target_o = pc_target_q;
    assign epc_o       = epc_q;
    assign in_svc_o    = in_svc_q;
    assign cur_irq_o   = cur_q;
    assign pending_o   = pending_q;
    assign mask_o      = mask_q;

endmodule

// File: tb/tb_int_sched.sv
// tb/tb_int_sched.sv - directed vector bench for int_sched
module tb_int_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_i;
    logic        ie_i, halt_i, stall_i, mask_we_i, eret_i;
    logic [2:0]  mask_din_i;
    logic [31:0] npc_i;
    logic        interrupt_o, pc_load_o, in_svc_o;
    logic [31:0] pc_target_o, epc_o;
    logic [1:0]  cur_irq_o;
    logic [2:0]  pending_o, mask_o;

    int n_checks = 0;
    int n_errors = 0;

    int_sched dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .ie_i(ie_i), .halt_i(halt_i),
        .stall_i(stall_i), .mask_we_i(mask_we_i), .mask_din_i(mask_din_i),
        .npc_i(npc_i), .eret_i(eret_i), .interrupt_o(interrupt_o),
        .pc_load_o(pc_load_o), .pc_target_o(pc_target_o), .epc_o(epc_o),
        .in_svc_o(in_svc_o), .cur_irq_o(cur_irq_o), .pending_o(pending_o),
        .mask_o(mask_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  irq;
        logic        eret;
        logic [31:0] npc;
        logic        e_int;
        logic        e_pcl;
        logic        e_svc;
        logic [31:0] e_tgt;
        logic [31:0] e_epc;
        logic [1:0]  e_cur;
        logic [2:0]  e_pend;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         rst irq     eret npc        int pcl svc tgt        epc        cur pend
        tbl[0]  = '{0, 3'b000, 0, 32'h40,     0,  0,  0, 32'h0,     32'h0,     0, 3'b000};
        tbl[1]  = '{1, 3'b000, 0, 32'h40,     0,  0,  0, 32'h0,     32'h0,     0, 3'b000};
        tbl[2]  = '{1, 3'b010, 0, 32'h40,     0,  0,  0, 32'h0,     32'h0,     0, 3'b010};
        tbl[3]  = '{1, 3'b000, 0, 32'h40,     1,  1,  1, 32'h110,   32'h40,    1, 3'b000};
        tbl[4]  = '{1, 3'b000, 0, 32'h40,     0,  0,  1, 32'h0,     32'h40,    1, 3'b000};
        tbl[5]  = '{1, 3'b000, 1, 32'h40,     0,  1,  0, 32'h40,    32'h40,    1, 3'b000};
        tbl[6]  = '{1, 3'b000, 0, 32'h40,     0,  0,  0, 32'h0,     32'h40,    1, 3'b000};
        tbl[7]  = '{1, 3'b101, 0, 32'h80,     0,  0,  0, 32'h0,     32'h40,    1, 3'b101};
        tbl[8]  = '{1, 3'b101, 0, 32'h80,     1,  1,  1, 32'h100,   32'h80,    0, 3'b100};
        tbl[9]  = '{1, 3'b000, 0, 32'h80,     0,  0,  1, 32'h0,     32'h80,    0, 3'b100};
        tbl[10] = '{1, 3'b000, 1, 32'h90,     0,  1,  0, 32'h80,    32'h80,    0, 3'b100};
        tbl[11] = '{1, 3'b000, 0, 32'h90,     0,  0,  0, 32'h0,     32'h80,    0, 3'b100};
        tbl[12] = '{1, 3'b000, 0, 32'h90,     1,  1,  1, 32'h120,   32'h90,    2, 3'b000};
        tbl[13] = '{1, 3'b000, 0, 32'h90,     0,  0,  1, 32'h0,     32'h90,    2, 3'b000};
        tbl[14] = '{1, 3'b000, 1, 32'h90,     0,  1,  0, 32'h90,    32'h90,    2, 3'b000};
        tbl[15] = '{1, 3'b000, 0, 32'h90,     0,  0,  0, 32'h0,     32'h90,    2, 3'b000};
        tbl[16] = '{1, 3'b000, 1, 32'h90,     0,  0,  0, 32'h0,     32'h90,    2, 3'b000};

        ie_i = 1'b1; halt_i = 1'b0; stall_i = 1'b0;
        mask_we_i = 1'b0; mask_din_i = 3'b000;

        for (int i = 0; i < 17; i++) begin
            rst    = tbl[i].rst;
            irq_i  = tbl[i].irq;
            eret_i = tbl[i].eret;
            npc_i  = tbl[i].npc;
            step();
            chk($sformatf("v%0d interrupt", i), 32'(interrupt_o), 32'(tbl[i].e_int));
            chk($sformatf("v%0d pc_load", i),   32'(pc_load_o),   32'(tbl[i].e_pcl));
            chk($sformatf("v%0d in_svc", i),    32'(in_svc_o),    32'(tbl[i].e_svc));
            chk($sformatf("v%0d epc", i),       epc_o,            tbl[i].e_epc);
            chk($sformatf("v%0d cur", i),       32'(cur_irq_o),   32'(tbl[i].e_cur));
            chk($sformatf("v%0d pending", i),   32'(pending_o),   32'(tbl[i].e_pend));
            chk($sformatf("v%0d mask", i),      32'(mask_o),      32'h0);
            if (tbl[i].e_pcl || !tbl[i].rst)
                chk($sformatf("v%0d target", i), pc_target_o, tbl[i].e_tgt);
        end
        eret_i = 1'b0;

        // Each blocker defers the take while keeping the request pending.
        for (int b = 0; b < 3; b++) begin
            ie_i = (b != 0); halt_i = (b == 1); stall_i = (b == 2);
            irq_i = 3'b001; step();
            irq_i = 3'b000; step(); step();
            chk($sformatf("blk%0d no pulse", b), 32'(interrupt_o), 32'h0);
            chk($sformatf("blk%0d pending held", b), 32'(pending_o), 32'h1);
            ie_i = 1'b1; halt_i = 1'b0; stall_i = 1'b0;
            step();
            chk($sformatf("blk%0d pulse", b), 32'(interrupt_o), 32'h1);
            chk($sformatf("blk%0d target", b), pc_target_o, 32'h100);
            step();
            eret_i = 1'b1; step();
            eret_i = 1'b0; step();
        end

        // Mask written in the take cycle: arbitration sees the old mask.
        irq_i = 3'b001; step();
        irq_i = 3'b000; mask_we_i = 1'b1; mask_din_i = 3'b001; step();
        mask_we_i = 1'b0;
        chk("mask old pulse", 32'(interrupt_o), 32'h1);
        chk("mask written", 32'(mask_o), 32'h1);
        step();
        eret_i = 1'b1; step();
        eret_i = 1'b0; step();
        irq_i = 3'b001; step();
        irq_i = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("masked no pulse %0d", k), 32'(interrupt_o), 32'h0);
            chk($sformatf("masked pending %0d", k), 32'(pending_o), 32'h1);
        end
        mask_we_i = 1'b1; mask_din_i = 3'b000; step();
        mask_we_i = 1'b0;
        chk("unmask same cycle", 32'(interrupt_o), 32'h0);
        step();
        chk("unmask take", 32'(interrupt_o), 32'h1);
        step();
        eret_i = 1'b1; step();
        eret_i = 1'b0; step();

        // New edge on the in-service source re-pends and is served after RET.
        irq_i = 3'b010; step();
        irq_i = 3'b000; step();
        chk("resvc take cur", 32'(cur_irq_o), 32'h1);
        step();
        irq_i = 3'b010; step();
        irq_i = 3'b000;
        chk("resvc in_svc", 32'(in_svc_o), 32'h1);
        chk("resvc repended", 32'(pending_o), 32'h2);
        eret_i = 1'b1; npc_i = 32'h200; step();
        eret_i = 1'b0;
        chk("resvc ret pc_load", 32'(pc_load_o), 32'h1);
        step();
        chk("resvc idle gap", 32'(interrupt_o), 32'h0);
        step();
        chk("resvc retake", 32'(interrupt_o), 32'h1);
        chk("resvc retake target", pc_target_o, 32'h110);
        step();

        // Reset in SERVE clears everything, including a non-default mask.
        mask_we_i = 1'b1; mask_din_i = 3'b110; irq_i = 3'b100; step();
        mask_we_i = 1'b0;
        chk("pre-rst mask", 32'(mask_o), 32'h6);
        chk("pre-rst pending", 32'(pending_o), 32'h4);
        rst = 1'b0; step();
        chk("rst in_svc", 32'(in_svc_o), 32'h0);
        chk("rst pc_load", 32'(pc_load_o), 32'h0);
        chk("rst interrupt", 32'(interrupt_o), 32'h0);
        chk("rst pending", 32'(pending_o), 32'h0);
        chk("rst epc", epc_o, 32'h0);
        chk("rst mask", 32'(mask_o), 32'h0);
        chk("rst cur", 32'(cur_irq_o), 32'h0);
        rst = 1'b1; step();
        chk("held line edge after rst", 32'(pending_o), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
